// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - scanner-side model of one 3x3 keypad key with optional contact bounce
// Presses are requested over key_valid/key_ready. The latched key pulls its column low while its row is scanned.
module keypad_emulator #(
    parameter int PRESS_CYCLES   = 1200000,
    parameter int RELEASE_CYCLES = 1200000,
    parameter int BOUNCE_CYCLES  = 12000,
    parameter int BOUNCE_TOGGLE  = 600,
    parameter int CNT_W          = 24
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       keypad_r1,
    input  logic       keypad_r2,
    input  logic       keypad_r3,
    output logic       keypad_c1,
    output logic       keypad_c2,
    output logic       keypad_c3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BNC_IN,
        S_HOLD,
        S_BNC_OUT,
        S_GAP
    } state_t;

    // Each state is loaded with its length minus one and exits on the cycle the count is zero.
    localparam logic [CNT_W-1:0] PRESS_LD   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LD  = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TOGGLE_LD  = CNT_W'(BOUNCE_TOGGLE - 1);
    localparam bit               HAS_BOUNCE = (BOUNCE_CYCLES > 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tgl_q, tgl_d;
    logic             contact_q, contact_d;
    logic [1:0]       key_row_q, key_row_d;
    logic [1:0]       key_col_q, key_col_d;
    logic             ready_q, busy_q, done_q, err_q;
    logic             done_d, err_d;
    logic [2:0]       cols_q, cols_d;

    logic             code_ok;
    logic [1:0]       code_row;
    logic [1:0]       code_col;
    logic             row_lvl;

    always_comb begin
        code_ok  = 1'b1;
        code_row = 2'd0;
        code_col = 2'd0;
        case (key_code)
            4'd1: begin code_row = 2'd0; code_col = 2'd0; end
            4'd2: begin code_row = 2'd0; code_col = 2'd1; end
            4'd3: begin code_row = 2'd0; code_col = 2'd2; end
            4'd4: begin code_row = 2'd1; code_col = 2'd0; end
            4'd5: begin code_row = 2'd1; code_col = 2'd1; end
            4'd6: begin code_row = 2'd1; code_col = 2'd2; end
            4'd7: begin code_row = 2'd2; code_col = 2'd0; end
            4'd8: begin code_row = 2'd2; code_col = 2'd1; end
            4'd9: begin code_row = 2'd2; code_col = 2'd2; end
            default: code_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgl_d     = tgl_q;
        contact_d = contact_q;
        key_row_d = key_row_q;
        key_col_d = key_col_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                contact_d = 1'b0;
                if (key_valid && ready_q) begin
                    if (code_ok) begin
                        key_row_d = code_row;
                        key_col_d = code_col;
                        contact_d = 1'b1;
                        tgl_d     = TOGGLE_LD;
                        if (HAS_BOUNCE) begin
                            state_d = S_BNC_IN;
                            cnt_d   = BOUNCE_LD;
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = PRESS_LD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_BNC_IN, S_BNC_OUT: begin
                if (cnt_q == '0) begin
                    if (state_q == S_BNC_IN) begin
                        state_d   = S_HOLD;
                        cnt_d     = PRESS_LD;
                        contact_d = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        cnt_d     = RELEASE_LD;
                        contact_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (tgl_q == '0) begin
                        contact_d = ~contact_q;
                        tgl_d     = TOGGLE_LD;
                    end else begin
                        tgl_d = tgl_q - 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    contact_d = 1'b0;
                    tgl_d     = TOGGLE_LD;
                    if (HAS_BOUNCE) begin
                        state_d = S_BNC_OUT;
                        cnt_d   = BOUNCE_LD;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = RELEASE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    // Columns reflect the contact of the coming cycle against the rows sampled on this edge.
    always_comb begin
        case (key_row_d)
            2'd0:    row_lvl = keypad_r1;
            2'd1:    row_lvl = keypad_r2;
            default: row_lvl = keypad_r3;
        endcase
        cols_d = 3'b111;
        if (contact_d && !row_lvl) begin
            case (key_col_d)
                2'd0:    cols_d = 3'b110;
                2'd1:    cols_d = 3'b101;
                default: cols_d = 3'b011;
            endcase
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tgl_q     <= '0;
            contact_q <= 1'b0;
            key_row_q <= 2'd0;
            key_col_q <= 2'd0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cols_q    <= 3'b111;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgl_q     <= tgl_d;
            contact_q <= contact_d;
            key_row_q <= key_row_d;
            key_col_q <= key_col_d;
            ready_q   <= (state_d == S_IDLE);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
            err_q     <= err_d;
            cols_q    <= cols_d;
        end
    end

    assign key_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign keypad_c1 = cols_q[0];
    assign keypad_c2 = cols_q[1];
    assign keypad_c3 = cols_q[2];

endmodule
